// File: rtl/dac_pkg.sv
// Shared constants for the dual-channel Pmod DAC writer: frame geometry,
// one-hot FSM state codes and the frame-building helper.
package dac_pkg;

   localparam int FRAME_W = 16;
   localparam int DATA_W  = 12;
   localparam int PAD_W   = 4;

   // One-hot state codes, same style as the pong_top FSM
   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_SHIFT = 3'b010;
   localparam logic [2:0] ST_QUIET = 3'b100;

   // Pad/mode bits are all zero: normal operation
   function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] d);
      return {{PAD_W{1'b0}}, d};
   endfunction

endpackage

// File: rtl/pmod_dac_writer_sclk_divider.sv
// SCLK generator for the DAC writer. Idles high while disabled and toggles
// every CLK_DIV enabled cycles; rise/fall strobes mark the cycle whose
// closing clock edge produces the corresponding sclk transition.
module sclk_divider #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sclk_q, sclk_d;
   logic             tick;

   // Half-period counter; disabling clears it so each frame starts aligned
   always_comb begin
      tick      = en_i && (div_cnt_q == DIV_W'(CLK_DIV - 1));
      div_cnt_d = div_cnt_q;
      sclk_d    = sclk_q;
      if (!en_i) begin
         div_cnt_d = '0;
         sclk_d    = 1'b1;
      end else if (tick) begin
         div_cnt_d = '0;
         sclk_d    = ~sclk_q;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // Divider state registers with synchronous reset to the idle level
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         sclk_q    <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         sclk_q    <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = tick && !sclk_q;
   assign fall_o = tick && sclk_q;

endmodule

// File: rtl/pmod_dac_writer.sv
// Serial writer for a dual-channel 12-bit Pmod DAC. Two 16-bit frames are
// shifted out MSB first on din_a/din_b under a shared sclk and sync_n,
// followed by a quiet gap that ends with a one-cycle done pulse.
module pmod_dac_writer
   import dac_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int QUIET_CYC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   output logic              busy,
   output logic              done,
   output logic              sync_n,
   output logic              sclk,
   output logic              din_a,
   output logic              din_b
);

   localparam int QW = $clog2(QUIET_CYC + 1);

   logic [2:0]         state_q, state_d;
   logic [FRAME_W-1:0] shift_a_q, shift_a_d;
   logic [FRAME_W-1:0] shift_b_q, shift_b_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [QW-1:0]      quiet_cnt_q, quiet_cnt_d;
   logic               sync_n_q, sync_n_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               sclk_rise;
   // DAC samples on this edge; the writer itself has nothing to do there
   logic               sclk_fall_unused;

   sclk_divider #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clk    (clk),
      .reset  (reset),
      .en_i   (state_q == ST_SHIFT),
      .sclk_o (sclk),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall_unused)
   );

   // Frame sequencing: accept, shift on sclk rises, quiet gap, done
   always_comb begin
      state_d     = state_q;
      shift_a_d   = shift_a_q;
      shift_b_d   = shift_b_q;
      bit_cnt_d   = bit_cnt_q;
      quiet_cnt_d = quiet_cnt_q;
      sync_n_d    = sync_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !busy_q) begin
               shift_a_d = make_frame(data_a);
               shift_b_d = make_frame(data_b);
               bit_cnt_d = '0;
               sync_n_d  = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               if (bit_cnt_q != 4'd15) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shift_a_d = {shift_a_q[FRAME_W-2:0], 1'b0};
                  shift_b_d = {shift_b_q[FRAME_W-2:0], 1'b0};
               end else begin
                  // din comes from the shifter MSB, so clearing it parks din low
                  shift_a_d   = '0;
                  shift_b_d   = '0;
                  sync_n_d    = 1'b1;
                  quiet_cnt_d = '0;
                  state_d     = ST_QUIET;
               end
            end
         end
         ST_QUIET: begin
            if (quiet_cnt_q == QW'(QUIET_CYC - 1)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               quiet_cnt_d = quiet_cnt_q + QW'(1);
            end
         end
         default: begin
            shift_a_d = '0;
            shift_b_d = '0;
            sync_n_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // FSM and datapath registers; reset aborts any frame without done
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_a_q   <= '0;
         shift_b_q   <= '0;
         bit_cnt_q   <= '0;
         quiet_cnt_q <= '0;
         sync_n_q    <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_a_q   <= shift_a_d;
         shift_b_q   <= shift_b_d;
         bit_cnt_q   <= bit_cnt_d;
         quiet_cnt_q <= quiet_cnt_d;
         sync_n_q    <= sync_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign sync_n = sync_n_q;
   assign din_a  = shift_a_q[FRAME_W-1];
   assign din_b  = shift_b_q[FRAME_W-1];

endmodule

// File: tb/tb_pmod_dac_writer.sv
// Bench for pmod_dac_writer: two instances (CLK_DIV=1 and CLK_DIV=2) share
// clock and reset; frames are captured as the DAC would see them and
// compared with the zero-padded sample values.
module tb_pmod_dac_writer;

   localparam int QC = 4;

   logic clk;
   logic reset;
   logic st1, st2;
   logic [11:0] da1, db1, da2, db2;
   logic busy1, done1, sn1, sc1, dina1, dinb1;
   logic busy2, done2, sn2, sc2, dina2, dinb2;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pmod_dac_writer #(.CLK_DIV(1), .QUIET_CYC(QC)) dut1 (
      .clk(clk), .reset(reset), .start(st1), .data_a(da1), .data_b(db1),
      .busy(busy1), .done(done1), .sync_n(sn1), .sclk(sc1),
      .din_a(dina1), .din_b(dinb1)
   );

   pmod_dac_writer #(.CLK_DIV(2), .QUIET_CYC(QC)) dut2 (
      .clk(clk), .reset(reset), .start(st2), .data_a(da2), .data_b(db2),
      .busy(busy2), .done(done2), .sync_n(sn2), .sclk(sc2),
      .din_a(dina2), .din_b(dinb2)
   );

   // {sync_n, sclk, din_a, din_b, busy, done} of the selected instance
   function automatic logic [5:0] outs(input int sel);
      return (sel == 1) ? {sn1, sc1, dina1, dinb1, busy1, done1}
                        : {sn2, sc2, dina2, dinb2, busy2, done2};
   endfunction

   task automatic drive(input int sel, input logic s, input logic [11:0] a, input logic [11:0] b);
      if (sel == 1) begin st1 = s; da1 = a; db1 = b; end
      else          begin st2 = s; da2 = a; db2 = b; end
   endtask

   // Observe one frame as the DAC does: bits taken at sclk falls while sync_n
   // is low; also measures sync_n low time and cycles from sync_n rise to done.
   task automatic capture(input int sel, input logic keep, input logic [11:0] ja, input logic [11:0] jb,
                          output logic [15:0] ga, output logic [15:0] gb, output int low,
                          output int nf, output int qg, output int lat, output logic to, output logic bb);
      logic [5:0] o;
      logic prev;
      ga = '0; gb = '0; low = 0; nf = 0; qg = 0; lat = 0; to = 1'b0; bb = 1'b0;
      o = outs(sel);
      while (o[5] !== 1'b0 && lat < 20) begin
         @(negedge clk); lat++; o = outs(sel);
      end
      if (o[5] !== 1'b0) begin to = 1'b1; return; end
      prev = 1'b1;
      while (o[5] === 1'b0 && low < 400) begin
         low++;
         if (o[1] !== 1'b1 || o[0] !== 1'b0) bb = 1'b1;
         if (prev === 1'b1 && o[4] === 1'b0) begin
            ga = {ga[14:0], o[3]};
            gb = {gb[14:0], o[2]};
            nf++;
         end
         prev = o[4];
         drive(sel, keep, ja, jb);
         @(negedge clk); o = outs(sel);
      end
      if (o[5] === 1'b0) begin to = 1'b1; return; end
      while (o[0] !== 1'b1 && qg < 50) begin
         qg++;
         if (o[5] !== 1'b1 || o[4] !== 1'b1 || o[1] !== 1'b1 || o[3] !== 1'b0 || o[2] !== 1'b0) bb = 1'b1;
         drive(sel, keep, ja, jb);
         @(negedge clk); o = outs(sel);
      end
      if (o[0] !== 1'b1) to = 1'b1;
      else if (o[1] !== 1'b0 || o[5] !== 1'b1) bb = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1, 1'b0, 12'h000, 12'h000);
      drive(2, 1'b0, 12'h000, 12'h000);
      repeat (3) @(negedge clk);
      checks++;
      if ({sn2, sc2, dina2, dinb2, busy2, done2} !== 6'b110000) begin
         errors++; $display("FAIL reset_state: got %b expected 110000", {sn2, sc2, dina2, dinb2, busy2, done2});
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({sn1, sc1, dina1, dinb1, busy1, done1, sn2, sc2, dina2, dinb2, busy2, done2} !== 12'b110000_110000) begin
            errors++;
            $display("FAIL idle_cycle%0d: got %b expected 110000110000", i,
                     {sn1, sc1, dina1, dinb1, busy1, done1, sn2, sc2, dina2, dinb2, busy2, done2});
         end
      end
   endtask

   task automatic test_basic();
      logic [15:0] ga, gb; int low, nf, qg, lat; logic to, bb;
      logic [11:0] a, b;
      for (int n = 0; n < 6; n++) begin
         a = (n == 0) ? 12'hABC : 12'($urandom);
         b = (n == 0) ? 12'h123 : 12'($urandom);
         @(negedge clk); drive(2, 1'b1, a, b);
         capture(2, 1'b0, ~a, ~b, ga, gb, low, nf, qg, lat, to, bb);
         checks++; if (to)          begin errors++; $display("FAIL basic%0d_timeout: got 1 expected 0", n); end
         checks++; if (ga !== 16'(a)) begin errors++; $display("FAIL basic%0d_din_a: got %h expected %h", n, ga, 16'(a)); end
         checks++; if (gb !== 16'(b)) begin errors++; $display("FAIL basic%0d_din_b: got %h expected %h", n, gb, 16'(b)); end
         checks++; if (low !== 64)  begin errors++; $display("FAIL basic%0d_sync_low: got %0d expected 64", n, low); end
         checks++; if (nf !== 16)   begin errors++; $display("FAIL basic%0d_falls: got %0d expected 16", n, nf); end
         checks++; if (qg !== QC)   begin errors++; $display("FAIL basic%0d_quiet: got %0d expected %0d", n, qg, QC); end
         checks++; if (lat !== 1)   begin errors++; $display("FAIL basic%0d_start_lat: got %0d expected 1", n, lat); end
         checks++; if (bb)          begin errors++; $display("FAIL basic%0d_busy_done_shape: got 1 expected 0", n); end
         @(negedge clk);
         checks++;
         if ({done2, busy2, sn2, sc2} !== 4'b0011) begin
            errors++; $display("FAIL basic%0d_after_done: got %b expected 0011", n, {done2, busy2, sn2, sc2});
         end
      end
   endtask

   task automatic test_ignore();
      logic [15:0] ga, gb; int low, nf, qg, lat; logic to, bb;
      @(negedge clk); drive(2, 1'b1, 12'hABC, 12'h123);
      capture(2, 1'b1, 12'hFFF, 12'hFFF, ga, gb, low, nf, qg, lat, to, bb);
      checks++; if (to || bb)       begin errors++; $display("FAIL ignore_shape: got to=%0b bb=%0b expected 0 0", to, bb); end
      checks++; if (ga !== 16'h0ABC) begin errors++; $display("FAIL ignore_din_a: got %h expected 0abc", ga); end
      checks++; if (gb !== 16'h0123) begin errors++; $display("FAIL ignore_din_b: got %h expected 0123", gb); end
      checks++; if (low !== 64 || qg !== QC) begin errors++; $display("FAIL ignore_timing: got low=%0d quiet=%0d expected 64 %0d", low, qg, QC); end
      // start still high in the done cycle: a second frame carrying FFF follows
      capture(2, 1'b0, 12'h000, 12'h000, ga, gb, low, nf, qg, lat, to, bb);
      checks++; if (lat !== 1)        begin errors++; $display("FAIL ignore_restart_lat: got %0d expected 1", lat); end
      checks++; if (ga !== 16'h0FFF || gb !== 16'h0FFF) begin errors++; $display("FAIL ignore_second: got %h %h expected 0fff 0fff", ga, gb); end
      @(negedge clk);
      checks++; if ({busy2, sn2} !== 2'b01) begin errors++; $display("FAIL ignore_idle: got %b expected 01", {busy2, sn2}); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ga, gb; int low, nf, qg, lat; logic to, bb;
      logic [11:0] ca, cb, na, nb;
      ca = 12'($urandom); cb = 12'($urandom);
      @(negedge clk); drive(2, 1'b1, ca, cb);
      for (int k = 0; k < 4; k++) begin
         na = 12'($urandom); nb = 12'($urandom);
         capture(2, 1'b1, na, nb, ga, gb, low, nf, qg, lat, to, bb);
         checks++; if (to || bb) begin errors++; $display("FAIL b2b%0d_shape: got to=%0b bb=%0b expected 0 0", k, to, bb); end
         checks++; if (ga !== 16'(ca) || gb !== 16'(cb)) begin
            errors++; $display("FAIL b2b%0d_data: got %h %h expected %h %h", k, ga, gb, 16'(ca), 16'(cb));
         end
         // sync_n high time between frames = quiet cycles + the done cycle
         checks++; if (k > 0 && lat !== 1) begin errors++; $display("FAIL b2b%0d_gap: got %0d expected %0d", k, QC + lat, QC + 1); end
         checks++; if (qg !== QC || low !== 64) begin errors++; $display("FAIL b2b%0d_timing: got %0d %0d expected %0d 64", k, qg, low, QC); end
         ca = na; cb = nb;
      end
      drive(2, 1'b0, 12'h000, 12'h000);
      @(negedge clk);
      checks++; if ({busy2, sn2} !== 2'b01) begin errors++; $display("FAIL b2b_stop: got %b expected 01", {busy2, sn2}); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] ga, gb; int low, nf, qg, lat; logic to, bb;
      logic [11:0] a, b;
      logic prev; int falls, w; logic seen_done;
      @(negedge clk); drive(2, 1'b1, 12'h5A5, 12'hA5A);
      @(negedge clk); drive(2, 1'b0, 12'h000, 12'h000);
      prev = 1'b1; falls = 0; w = 0;
      while (falls < 8 && w < 200) begin
         @(negedge clk); w++;
         if (prev === 1'b1 && sc2 === 1'b0) falls++;
         prev = sc2;
      end
      checks++; if (falls !== 8) begin errors++; $display("FAIL rstmid_reach: got %0d expected 8", falls); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({sn2, sc2, dina2, dinb2, busy2, done2} !== 6'b110000) begin
         errors++; $display("FAIL rstmid_state: got %b expected 110000", {sn2, sc2, dina2, dinb2, busy2, done2});
      end
      reset = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done2 !== 1'b0 || sn2 !== 1'b1) seen_done = 1'b1;
      end
      checks++; if (seen_done) begin errors++; $display("FAIL rstmid_no_done: got 1 expected 0"); end
      a = 12'($urandom); b = 12'($urandom);
      @(negedge clk); drive(2, 1'b1, a, b);
      capture(2, 1'b0, 12'h000, 12'h000, ga, gb, low, nf, qg, lat, to, bb);
      checks++; if (to || bb || low !== 64 || nf !== 16) begin
         errors++; $display("FAIL rstmid_frame_shape: got to=%0b bb=%0b low=%0d nf=%0d expected 0 0 64 16", to, bb, low, nf);
      end
      checks++; if (ga !== 16'(a) || gb !== 16'(b)) begin
         errors++; $display("FAIL rstmid_frame_data: got %h %h expected %h %h", ga, gb, 16'(a), 16'(b));
      end
      @(negedge clk);
   endtask

   task automatic test_div1();
      logic [15:0] ga, gb; int low, nf, qg, lat; logic to, bb;
      logic [11:0] a, b;
      for (int n = 0; n < 4; n++) begin
         a = (n == 0) ? 12'h000 : 12'($urandom);
         b = (n == 0) ? 12'h800 : 12'($urandom);
         @(negedge clk); drive(1, 1'b1, a, b);
         capture(1, 1'b0, ~a, ~b, ga, gb, low, nf, qg, lat, to, bb);
         checks++; if (to || bb || lat !== 1) begin errors++; $display("FAIL div1_%0d_shape: got to=%0b bb=%0b lat=%0d expected 0 0 1", n, to, bb, lat); end
         checks++; if (ga !== 16'(a)) begin errors++; $display("FAIL div1_%0d_din_a: got %h expected %h", n, ga, 16'(a)); end
         checks++; if (gb !== 16'(b)) begin errors++; $display("FAIL div1_%0d_din_b: got %h expected %h", n, gb, 16'(b)); end
         checks++; if (low !== 32 || nf !== 16) begin errors++; $display("FAIL div1_%0d_timing: got low=%0d nf=%0d expected 32 16", n, low, nf); end
         checks++; if (qg !== QC) begin errors++; $display("FAIL div1_%0d_quiet: got %0d expected %0d", n, qg, QC); end
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      test_div1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
